// File: rtl/accel_pkg.sv
// Shared definitions for accel_dma: emesh packet layout, register map, copy FSM encoding.
// The optional done interrupt is built only when ACCEL_DMA_IRQ_EN is defined.
package accel_pkg;

    localparam int AW = 32;
    localparam int PW = 2 * AW + 40;

    localparam int P_WRITE   = 0;
    localparam int P_DMODE   = 1;
    localparam int P_CTRL    = 3;
    localparam int P_DSTADDR = 8;
    localparam int P_DATA    = 40;
    localparam int P_SRCADDR = 72;

    localparam logic [1:0]    DMODE_32   = 2'b10;
    localparam logic [AW-1:0] RETURN_TAG = 32'h8100_0000;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_SRC    = 3'd1;
    localparam logic [2:0] REG_DST    = 3'd2;
    localparam logic [2:0] REG_COUNT  = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RDREQ  = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_WRREQ  = 2'd3
    } state_t;

    // Every packet this block issues is a 32-bit access with ctrlmode 0.
    function automatic logic [PW-1:0] pack_pkt(input logic          wr,
                                               input logic [AW-1:0] dst,
                                               input logic [AW-1:0] data,
                                               input logic [AW-1:0] src);
        logic [PW-1:0] p;
        p = '0;
        p[P_WRITE]            = wr;
        p[P_DMODE +: 2]       = DMODE_32;
        p[P_DSTADDR +: AW]    = dst;
        p[P_DATA +: AW]       = data;
        p[P_SRCADDR +: AW]    = src;
        return p;
    endfunction

endpackage

// File: rtl/accel_dma_regs.sv
// Register file for accel_dma: write decode, read response path and slave-side wait logic.
// With ACCEL_DMA_IRQ_EN defined, CTRL bit1 is an irq enable and irq = done & irq_enable.
module accel_dma_regs
    import accel_pkg::*;
(
    input  logic          clk,
    input  logic          nreset,
    input  logic          s_wr_access,
    input  logic [PW-1:0] s_wr_packet,
    output logic          s_wr_wait,
    input  logic          s_rd_access,
    input  logic [PW-1:0] s_rd_packet,
    output logic          s_rd_wait,
    output logic          s_rr_access,
    output logic [PW-1:0] s_rr_packet,
    input  logic          s_rr_wait,
    input  logic          busy,
    input  logic          done_set,
    output logic          start,
    output logic [AW-1:0] src_reg,
    output logic [AW-1:0] dst_reg,
    output logic [15:0]   count_reg,
    output logic          irq
);

    // Handshake: a transfer happens on the rising edge where access=1 and wait=0;
    // while wait=1 the sender holds access and packet unchanged.

    logic [2:0]    wr_off;
    logic [AW-1:0] wr_data;
    logic [2:0]    rd_off;
    logic [AW-1:0] rd_val;
    logic [AW-1:0] ctrl_val;
    logic          rd_accept;
    logic          done;

    assign wr_off    = s_wr_packet[P_DSTADDR + 2 +: 3];
    assign wr_data   = s_wr_packet[P_DATA +: AW];
    assign rd_off    = s_rd_packet[P_DSTADDR + 2 +: 3];
    assign s_wr_wait = 1'b0;
    assign s_rd_wait = s_rr_access & s_rr_wait;
    assign rd_accept = s_rd_access & ~s_rd_wait;
    assign start     = s_wr_access & ~busy & (wr_off == REG_CTRL) & wr_data[0];

    always_ff @(posedge clk) begin
        if (!nreset) begin
            src_reg   <= '0;
            dst_reg   <= '0;
            count_reg <= '0;
            done      <= 1'b0;
        end else begin
            if (s_wr_access && !busy) begin
                case (wr_off)
                    REG_SRC:   src_reg   <= wr_data;
                    REG_DST:   dst_reg   <= wr_data;
                    REG_COUNT: count_reg <= wr_data[15:0];
                    default:   ;
                endcase
            end
            // A completing copy outranks a simultaneous clear so the event is not lost.
            if (done_set)
                done <= 1'b1;
            else if (s_wr_access && (wr_off == REG_STATUS) && wr_data[1])
                done <= 1'b0;
        end
    end

`ifdef ACCEL_DMA_IRQ_EN
    logic irq_enable;

    always_ff @(posedge clk) begin
        if (!nreset)
            irq_enable <= 1'b0;
        else if (s_wr_access && !busy && (wr_off == REG_CTRL))
            irq_enable <= wr_data[1];
    end

    assign ctrl_val = {30'd0, irq_enable, 1'b0};
    assign irq      = done & irq_enable;
`else
    assign ctrl_val = '0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        case (rd_off)
            REG_CTRL:   rd_val = ctrl_val;
            REG_SRC:    rd_val = src_reg;
            REG_DST:    rd_val = dst_reg;
            REG_COUNT:  rd_val = {16'd0, count_reg};
            REG_STATUS: rd_val = {30'd0, done, busy};
            default:    rd_val = '0;
        endcase
    end

    // Response swaps the addresses so it routes back to the requester.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            s_rr_access <= 1'b0;
            s_rr_packet <= '0;
        end else if (rd_accept) begin
            s_rr_access <= 1'b1;
            s_rr_packet <= pack_pkt(1'b1, s_rd_packet[P_SRCADDR +: AW], rd_val,
                                    s_rd_packet[P_DSTADDR +: AW]);
        end else if (!s_rr_wait) begin
            s_rr_access <= 1'b0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s_wr_packet[P_DSTADDR-1:0], s_wr_packet[P_DSTADDR +: 2],
                           s_wr_packet[P_DSTADDR + 5 +: AW - 5], s_wr_packet[P_SRCADDR +: AW],
                           wr_data[AW-1:16],
                           s_rd_packet[P_DSTADDR-1:0], s_rd_packet[P_DSTADDR +: 2],
                           s_rd_packet[P_DSTADDR + 5 +: AW - 5], s_rd_packet[P_DATA +: AW]};

endmodule

// File: rtl/accel_dma.sv
// accel_dma top: memory-to-memory word copy engine with one read outstanding at a time.
// Optional done interrupt selected by ACCEL_DMA_IRQ_EN (see accel_dma_regs).
module accel_dma
    import accel_pkg::*;
(
    input  logic          clk,
    input  logic          nreset,
    input  logic          s_wr_access,
    input  logic [PW-1:0] s_wr_packet,
    output logic          s_wr_wait,
    input  logic          s_rd_access,
    input  logic [PW-1:0] s_rd_packet,
    output logic          s_rd_wait,
    output logic          s_rr_access,
    output logic [PW-1:0] s_rr_packet,
    input  logic          s_rr_wait,
    output logic          m_rd_access,
    output logic [PW-1:0] m_rd_packet,
    input  logic          m_rd_wait,
    input  logic          m_rr_access,
    input  logic [PW-1:0] m_rr_packet,
    output logic          m_rr_wait,
    output logic          m_wr_access,
    output logic [PW-1:0] m_wr_packet,
    input  logic          m_wr_wait,
    output logic          irq,
    output state_t        dbg_state
);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] src_w;
    logic [AW-1:0] dst_w;
    logic [15:0]   cnt_w;
    logic [AW-1:0] data_q;
    logic          busy;
    logic          done_set;
    logic          start;
    logic [AW-1:0] src_reg;
    logic [AW-1:0] dst_reg;
    logic [15:0]   count_reg;

    assign busy      = (state != ST_IDLE);
    assign m_rr_wait = 1'b0;
    assign dbg_state = state;

    accel_dma_regs u_regs (
        .clk         (clk),
        .nreset      (nreset),
        .s_wr_access (s_wr_access),
        .s_wr_packet (s_wr_packet),
        .s_wr_wait   (s_wr_wait),
        .s_rd_access (s_rd_access),
        .s_rd_packet (s_rd_packet),
        .s_rd_wait   (s_rd_wait),
        .s_rr_access (s_rr_access),
        .s_rr_packet (s_rr_packet),
        .s_rr_wait   (s_rr_wait),
        .busy        (busy),
        .done_set    (done_set),
        .start       (start),
        .src_reg     (src_reg),
        .dst_reg     (dst_reg),
        .count_reg   (count_reg),
        .irq         (irq)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state  <= ST_IDLE;
            src_w  <= '0;
            dst_w  <= '0;
            cnt_w  <= '0;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (start && count_reg != 16'd0) begin
                    src_w <= src_reg;
                    dst_w <= dst_reg;
                    cnt_w <= count_reg;
                end
                ST_RDWAIT: if (m_rr_access) data_q <= m_rr_packet[P_DATA +: AW];
                ST_WRREQ: if (!m_wr_wait) begin
                    src_w <= src_w + 32'd4;
                    dst_w <= dst_w + 32'd4;
                    cnt_w <= cnt_w - 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        m_rd_access = 1'b0;
        m_wr_access = 1'b0;
        done_set    = 1'b0;
        case (state)
            ST_IDLE: if (start) begin
                if (count_reg != 16'd0) state_nxt = ST_RDREQ;
                else                    done_set  = 1'b1;
            end
            ST_RDREQ: begin
                m_rd_access = 1'b1;
                if (!m_rd_wait) state_nxt = ST_RDWAIT;
            end
            ST_RDWAIT: if (m_rr_access) state_nxt = ST_WRREQ;
            ST_WRREQ: begin
                m_wr_access = 1'b1;
                if (!m_wr_wait) begin
                    if (cnt_w == 16'd1) begin
                        state_nxt = ST_IDLE;
                        done_set  = 1'b1;
                    end else begin
                        state_nxt = ST_RDREQ;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Packets are zeroed when idle so nothing but access-qualified content is visible.
    assign m_rd_packet = m_rd_access ? pack_pkt(1'b0, src_w, '0, RETURN_TAG) : '0;
    assign m_wr_packet = m_wr_access ? pack_pkt(1'b1, dst_w, data_q, '0) : '0;

    logic unused_rr;
    assign unused_rr = ^{m_rr_packet[P_DATA-1:0], m_rr_packet[P_SRCADDR +: AW]};

endmodule

// File: tb/tb_accel_dma.sv
// Directed self-checking bench for accel_dma: register access, copies, stalls, wrap, reset.
// Define ACCEL_DMA_IRQ_EN for both bench and RTL to exercise the interrupt build.
module tb_accel_dma;

    localparam int PW = 104;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          s_wr_access = 1'b0;
    logic [PW-1:0] s_wr_packet = '0;
    logic          s_wr_wait;
    logic          s_rd_access = 1'b0;
    logic [PW-1:0] s_rd_packet = '0;
    logic          s_rd_wait;
    logic          s_rr_access;
    logic [PW-1:0] s_rr_packet;
    logic          s_rr_wait = 1'b0;
    logic          m_rd_access;
    logic [PW-1:0] m_rd_packet;
    logic          m_rd_wait = 1'b0;
    logic          m_rr_access = 1'b0;
    logic [PW-1:0] m_rr_packet = '0;
    logic          m_rr_wait;
    logic          m_wr_access;
    logic [PW-1:0] m_wr_packet;
    logic          m_wr_wait = 1'b0;
    logic          irq;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    logic [31:0] rd_q[$];

    logic        resp_en   = 1'b1;
    logic        inject_rr = 1'b0;
    int          rr_cnt    = 0;
    logic [31:0] rr_addr   = '0;

    accel_dma dut (
        .clk         (clk),
        .nreset      (nreset),
        .s_wr_access (s_wr_access),
        .s_wr_packet (s_wr_packet),
        .s_wr_wait   (s_wr_wait),
        .s_rd_access (s_rd_access),
        .s_rd_packet (s_rd_packet),
        .s_rd_wait   (s_rd_wait),
        .s_rr_access (s_rr_access),
        .s_rr_packet (s_rr_packet),
        .s_rr_wait   (s_rr_wait),
        .m_rd_access (m_rd_access),
        .m_rd_packet (m_rd_packet),
        .m_rd_wait   (m_rd_wait),
        .m_rr_access (m_rr_access),
        .m_rr_packet (m_rr_packet),
        .m_rr_wait   (m_rr_wait),
        .m_wr_access (m_wr_access),
        .m_wr_packet (m_wr_packet),
        .m_wr_wait   (m_wr_wait),
        .irq         (irq),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mk(input logic wr, input logic [31:0] dst,
                                         input logic [31:0] data, input logic [31:0] src);
        return {src, data, dst, 5'd0, 2'b10, wr};
    endfunction

    // Memory model: returns {16'hD00D, addr[15:0]} two negedges after a read is taken.
    always @(negedge clk) begin
        m_rr_access = inject_rr;
        m_rr_packet = inject_rr ? mk(1'b1, 32'h8100_0000, 32'hBAD0_BAD0, 32'h0) : '0;
        if (rr_cnt > 0) begin
            rr_cnt = rr_cnt - 1;
            if (rr_cnt == 0) begin
                m_rr_access = 1'b1;
                m_rr_packet = mk(1'b1, 32'h8100_0000, {16'hD00D, rr_addr[15:0]}, 32'h0);
            end
        end
        if (m_rd_access && !m_rd_wait) begin
            rd_q.push_back(m_rd_packet[39:8]);
            if (resp_en) begin
                rr_addr = m_rd_packet[39:8];
                rr_cnt  = 2;
            end
        end
        if (m_wr_access && !m_wr_wait)
            obs_q.push_back({m_wr_packet[39:8], m_wr_packet[71:40]});
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] off, input logic [31:0] data);
        s_wr_access = 1'b1;
        s_wr_packet = mk(1'b1, {27'd0, off, 2'b00}, data, 32'h0);
        tick();
        s_wr_access = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] off, input logic [31:0] tag, output logic [31:0] data);
        s_rd_access = 1'b1;
        s_rd_packet = mk(1'b0, {27'd0, off, 2'b00}, 32'h0, tag);
        tick();
        s_rd_access = 1'b0;
        chk("rr_access", {63'd0, s_rr_access}, 64'd1);
        chk("rr_dstaddr", {32'd0, s_rr_packet[39:8]}, {32'd0, tag});
        data = s_rr_packet[71:40];
    endtask

    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] cnt, input logic [31:0] ctrl);
        wr_reg(3'd1, src);
        wr_reg(3'd2, dst);
        wr_reg(3'd3, cnt);
        wr_reg(3'd0, ctrl);
    endtask

    task automatic wait_obs(input int n);
        for (int i = 0; i < 300 && obs_q.size() < n; i++) tick();
        chk("wait_writes", 64'(obs_q.size()), 64'(n));
    endtask

    task automatic score(input string tag);
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0)
            chk(tag, obs_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic clear_all();
        logic [31:0] d;
        wr_reg(3'd4, 32'h2);
        rd_reg(3'd4, 32'h55, d);
        chk("status_cleared", {32'd0, d}, 64'h0);
        exp_q.delete();
        obs_q.delete();
        rd_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] d;
        logic [PW-1:0] held;

        repeat (3) tick();
        chk("rst_m_rd_access", {63'd0, m_rd_access}, 64'd0);
        chk("rst_m_wr_access", {63'd0, m_wr_access}, 64'd0);
        chk("rst_s_rr_access", {63'd0, s_rr_access}, 64'd0);
        chk("rst_m_rd_packet", 64'(m_rd_packet), 64'd0);
        chk("rst_irq", {63'd0, irq}, 64'd0);
        nreset = 1'b1;
        tick();
        rd_reg(3'd4, 32'hCAFE_0001, d);
        chk("rst_status", {32'd0, d}, 64'h0);
        chk("rr_srcaddr", {32'd0, s_rr_packet[103:72]}, 64'h10);

        // three-word copy, no stalls
        run_copy(32'h1000, 32'h2000, 32'd3, 32'h1);
        exp_q.push_back({32'h2000, 32'hD00D_1000});
        exp_q.push_back({32'h2004, 32'hD00D_1004});
        exp_q.push_back({32'h2008, 32'hD00D_1008});
        wait_obs(3);
        repeat (2) tick();
        chk("rd_count", 64'(rd_q.size()), 64'd3);
        chk("rd_addr0", {32'd0, rd_q[0]}, 64'h1000);
        chk("rd_addr1", {32'd0, rd_q[1]}, 64'h1004);
        chk("rd_addr2", {32'd0, rd_q[2]}, 64'h1008);
        score("copy3");
        rd_reg(3'd4, 32'h77, d);
        chk("status_done", {32'd0, d}, 64'h2);
        clear_all();

        // same copy, second write stalled for five cycles
        run_copy(32'h1000, 32'h2000, 32'd3, 32'h1);
        exp_q.push_back({32'h2000, 32'hD00D_1000});
        exp_q.push_back({32'h2004, 32'hD00D_1004});
        exp_q.push_back({32'h2008, 32'hD00D_1008});
        for (int i = 0; i < 100 && obs_q.size() < 1; i++) tick();
        m_wr_wait = 1'b1;
        for (int i = 0; i < 100 && !m_wr_access; i++) tick();
        chk("stall_wr_pkt", 64'(m_wr_packet[71:8]), {32'hD00D_1004, 32'h2004});
        held = m_wr_packet;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_access", {63'd0, m_wr_access}, 64'd1);
            chk("stall_stable", 64'(m_wr_packet ^ held), 64'd0);
        end
        m_wr_wait = 1'b0;
        wait_obs(3);
        repeat (5) tick();
        score("copy_stall");
        clear_all();

        // zero-length start
        wr_reg(3'd3, 32'h0);
        wr_reg(3'd0, 32'h1);
        rd_reg(3'd4, 32'h88, d);
        chk("zero_done", {32'd0, d}, 64'h2);
        repeat (8) tick();
        chk("zero_reads", 64'(rd_q.size()), 64'd0);
        chk("zero_writes", 64'(obs_q.size()), 64'd0);
        clear_all();

        // address wrap and COUNT write while busy
        run_copy(32'hFFFF_FFFC, 32'h3000, 32'd2, 32'h1);
        wr_reg(3'd3, 32'h5);
        exp_q.push_back({32'h3000, 32'hD00D_FFFC});
        exp_q.push_back({32'h3004, 32'hD00D_0000});
        wait_obs(2);
        repeat (2) tick();
        chk("wrap_rd0", {32'd0, rd_q[0]}, 64'hFFFF_FFFC);
        chk("wrap_rd1", {32'd0, rd_q[1]}, 64'h0);
        score("wrap");
        rd_reg(3'd3, 32'h99, d);
        chk("count_kept", {32'd0, d}, 64'h2);
        clear_all();

        // interrupt enable through CTRL bit1
        run_copy(32'h500, 32'h600, 32'd1, 32'h3);
        exp_q.push_back({32'h600, 32'hD00D_0500});
        wait_obs(1);
        repeat (2) tick();
        score("irq_copy");
`ifdef ACCEL_DMA_IRQ_EN
        chk("irq_high", {63'd0, irq}, 64'd1);
        rd_reg(3'd0, 32'hAA, d);
        chk("ctrl_readback", {32'd0, d}, 64'h2);
        wr_reg(3'd4, 32'h2);
        chk("irq_low", {63'd0, irq}, 64'd0);
`else
        chk("irq_tied", {63'd0, irq}, 64'd0);
        rd_reg(3'd0, 32'hAA, d);
        chk("ctrl_readback", {32'd0, d}, 64'h0);
`endif
        clear_all();

        // reset in the middle of a copy
        resp_en = 1'b0;
        run_copy(32'h40, 32'h80, 32'd1, 32'h1);
        for (int i = 0; i < 50 && dbg_state != 2'd2; i++) tick();
        chk("reach_rdwait", {62'd0, dbg_state}, 64'd2);
        nreset = 1'b0;
        tick();
        chk("mid_rst_m_rd", {63'd0, m_rd_access}, 64'd0);
        chk("mid_rst_m_wr", {63'd0, m_wr_access}, 64'd0);
        chk("mid_rst_s_rr", {63'd0, s_rr_access}, 64'd0);
        chk("mid_rst_irq", {63'd0, irq}, 64'd0);
        nreset = 1'b1;
        inject_rr = 1'b1;
        tick();
        inject_rr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("late_rr_no_wr", {63'd0, m_wr_access}, 64'd0);
        end
        chk("late_rr_writes", 64'(obs_q.size()), 64'd0);
        rd_reg(3'd1, 32'hBB, d);
        chk("src_after_rst", {32'd0, d}, 64'h0);
        rd_reg(3'd4, 32'hCC, d);
        chk("status_after_rst", {32'd0, d}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
